// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the shared serial pattern detector.
// Holds the FSM state encodings and the pattern-length clamp.
package seq_det_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Length 0 means a single-bit pattern; anything longer than the window is cut to the window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int pat_w);
        logic [3:0] res;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if (int'(len) > pat_w) begin
            res = 4'(pat_w);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/pattern_window_match.sv
// Shift-register window with a Mealy compare of the incoming bit against the
// low len bits of the pattern.
module pattern_window_match #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       len,
    input  logic             din,
    input  logic             shift_en,
    input  logic             clr,
    output logic             hit,
    output logic [PAT_W-1:0] window_q
);

    logic [PAT_W-1:0] next_s;
    logic [PAT_W-1:0] mask_s;

    // Compare the window as it would look after this bit, so a match fires in the same cycle.
    always_comb begin
        next_s = {window_q[PAT_W-2:0], din};
        mask_s = {PAT_W{1'b0}};
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (i < int'(len));
        end
        hit = shift_en && ((next_s & mask_s) == (pattern & mask_s));
    end

    // Window storage; clear wins over shift so a non-overlapping match restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= {PAT_W{1'b0}};
        end else if (clr) begin
            window_q <= {PAT_W{1'b0}};
        end else if (shift_en) begin
            window_q <= next_s;
        end else begin
            window_q <= window_q;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One programmable pattern detector shared round-robin among NREQ serial
// requesters; reports per-burst match counts on done.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_bit,
    input  logic [NREQ-1:0]  req_last,
    output logic [NREQ-1:0]  gnt,
    output logic             match,
    output logic             done_vld,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] done_count
);

    logic [1:0]       state_r;
    logic [ID_W-1:0]  winner_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [PAT_W-1:0] pat_r;
    logic [3:0]       len_r;
    logic             ovl_r;
    logic [CNT_W-1:0] cnt_r;

    logic [ID_W-1:0]  pick_s;
    logic [ID_W-1:0]  next_ptr_s;
    logic             accept_s;
    logic             bit_s;
    logic             last_s;
    logic             hit_s;
    logic             clr_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [PAT_W-1:0] window_unused_s;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        pick_s = rr_ptr_r;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                pick_s = ID_W'(idx);
            end else begin
                found  = found;
            end
        end
    end

    // Accepted-bit path, saturating match count and pointer rotation.
    always_comb begin
        accept_s = (state_r == ST_RUN) && req_valid[winner_r];
        bit_s    = req_bit[winner_r];
        last_s   = req_last[winner_r];
        clr_s    = (state_r == ST_IDLE) || (hit_s && !ovl_r);
        if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
        if (winner_r == ID_W'(NREQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = winner_r + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    pattern_window_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .pattern  (pat_r),
        .len      (len_r),
        .din      (bit_s),
        .shift_en (accept_s),
        .clr      (clr_s),
        .hit      (hit_s),
        .window_q (window_unused_s)
    );

    assign match = hit_s;

    // Burst FSM: arbitrate and latch config, stream bits, then report once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            winner_r   <= {ID_W{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
            pat_r      <= {PAT_W{1'b0}};
            len_r      <= 4'd1;
            ovl_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            gnt        <= {NREQ{1'b0}};
            done_vld   <= 1'b0;
            done_id    <= {ID_W{1'b0}};
            done_count <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_vld <= 1'b0;
                    if (|req_valid) begin
                        winner_r <= pick_s;
                        pat_r    <= cfg_pattern;
                        len_r    <= clamp_len(cfg_len, PAT_W);
                        ovl_r    <= cfg_overlap;
                        cnt_r    <= {CNT_W{1'b0}};
                        gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                        state_r  <= ST_RUN;
                    end else begin
                        gnt <= {NREQ{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        cnt_r <= cnt_next_s;
                        if (last_s) begin
                            state_r    <= ST_DONE;
                            gnt        <= {NREQ{1'b0}};
                            done_vld   <= 1'b1;
                            done_id    <= winner_r;
                            done_count <= cnt_next_s;
                        end
                    end
                end
                ST_DONE: begin
                    done_vld <= 1'b0;
                    rr_ptr_r <= next_ptr_s;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt      <= {NREQ{1'b0}};
                    done_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: scoreboard of expected done records,
// inline checks of grant and Mealy match per streamed bit.
module tb_seq_det_sched;

    logic       clk;
    logic       rst;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [3:0] req_valid;
    logic [3:0] req_bit;
    logic [3:0] req_last;
    logic [3:0] gnt;
    logic       match;
    logic       done_vld;
    logic [1:0] done_id;
    logic [7:0] done_count;
    logic [3:0] gnt2;
    logic       match2;
    logic       done_vld2;
    logic [1:0] done_id2;
    logic [1:0] done_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];

    seq_det_sched #(.NREQ(4), .PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .req_valid(req_valid), .req_bit(req_bit),
        .req_last(req_last), .gnt(gnt), .match(match), .done_vld(done_vld),
        .done_id(done_id), .done_count(done_count)
    );

    seq_det_sched #(.NREQ(4), .PAT_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .req_valid(req_valid), .req_bit(req_bit),
        .req_last(req_last), .gnt(gnt2), .match(match2), .done_vld(done_vld2),
        .done_id(done_id2), .done_count(done_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the wide-counter instance.
    always @(negedge clk) begin
        if (done_vld === 1'b1) begin
            if (q.size() == 0) begin
                chk("done_unexpected", {31'd0, done_vld}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_id", {30'd0, done_id}, e.id);
                chk("done_count", {24'd0, done_count}, e.cnt);
            end
        end
    end

    // Scoreboard for the 2-bit saturating counter instance.
    always @(negedge clk) begin
        if (done_vld2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("done2_unexpected", {31'd0, done_vld2}, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("done2_id", {30'd0, done_id2}, e.id);
                chk("done2_count", {30'd0, done_count2}, e.cnt);
            end
        end
    end

    // Stream one burst on requester r; bits[i] is the i-th bit sent, mexp[i] its expected match.
    task automatic run_burst(input int r, input logic [31:0] bits, input int n,
                             input logic [31:0] mexp, input int cnt,
                             input int stall_at, input int stall_len);
        exp_t e;
        int t;
        logic [7:0] sv_pat;
        logic [3:0] sv_len;
        logic       sv_ovl;
        logic [3:0] oh;
        oh = 4'd1 << r;
        e.id = r;
        e.cnt = cnt;
        q.push_back(e);
        e.cnt = (cnt > 3) ? 3 : cnt;
        q2.push_back(e);
        req_valid[r] = 1'b1;
        req_bit[r]   = bits[0];
        req_last[r]  = 1'b0;
        t = 0;
        while (gnt[r] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("grant_wait", {31'd0, (t < 20)}, 32'd1);
        chk("grant_onehot", {28'd0, gnt}, {28'd0, oh});
        sv_pat = cfg_pattern;
        sv_len = cfg_len;
        sv_ovl = cfg_overlap;
        cfg_pattern = ~cfg_pattern;
        cfg_len     = 4'd1;
        cfg_overlap = ~cfg_overlap;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                req_valid[r] = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    chk("stall_match", {31'd0, match}, 32'd0);
                    chk("stall_gnt", {28'd0, gnt}, {28'd0, oh});
                    @(negedge clk);
                end
                req_valid[r] = 1'b1;
            end
            req_bit[r]  = bits[i];
            req_last[r] = (i == n - 1);
            #1;
            chk($sformatf("match_r%0d_b%0d", r, i), {31'd0, match}, {31'd0, mexp[i]});
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        cfg_pattern  = sv_pat;
        cfg_len      = sv_len;
        cfg_overlap  = sv_ovl;
    endtask

    task automatic gap_to_grant(input int r, input string tag);
        int k;
        k = 0;
        while (gnt[r] !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(tag, k, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cfg_pattern = 8'h00;
        cfg_len = 4'd1;
        cfg_overlap = 1'b1;
        req_valid = 4'b0000;
        req_bit = 4'b0000;
        req_last = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_done_vld", {31'd0, done_vld}, 32'd0);
        chk("rst_done_id", {30'd0, done_id}, 32'd0);
        chk("rst_done_count", {24'd0, done_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {28'd0, gnt}, 32'd0);

        // Two simultaneous requesters: 0 then 1, then rotation gives 1 then 0.
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        run_burst(0, 32'b0110, 4, 32'b0100, 1, -1, 0);
        gap_to_grant(1, "gap_0_to_1");
        run_burst(1, 32'b111, 3, 32'b110, 2, -1, 0);
        @(negedge clk); @(negedge clk);
        run_burst(0, 32'b0110, 4, 32'b0100, 1, -1, 0);
        @(negedge clk); @(negedge clk);
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        run_burst(1, 32'b111, 3, 32'b110, 2, -1, 0);
        gap_to_grant(0, "gap_1_to_0");
        run_burst(0, 32'b0110, 4, 32'b0100, 1, -1, 0);
        @(negedge clk); @(negedge clk);

        // 10101 over 1010101, overlapping then non-overlapping.
        cfg_pattern = 8'h15; cfg_len = 4'd5; cfg_overlap = 1'b1;
        run_burst(0, 32'b1010101, 7, 32'b1010000, 2, -1, 0);
        @(negedge clk); @(negedge clk);
        cfg_overlap = 1'b0;
        run_burst(0, 32'b1010101, 7, 32'b0010000, 1, -1, 0);
        @(negedge clk); @(negedge clk);

        // Requester 2 with a 5-cycle valid gap mid-burst.
        cfg_overlap = 1'b1;
        run_burst(2, 32'b1010101, 7, 32'b1010000, 2, 3, 5);
        @(negedge clk); @(negedge clk);

        // Reset mid-burst after 3 accepted bits: no done for the aborted burst.
        req_valid[0] = 1'b1; req_bit[0] = 1'b1; req_last[0] = 1'b0;
        @(negedge clk);
        chk("abort_gnt", {28'd0, gnt}, 32'd1);
        repeat (3) @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_rst_gnt", {28'd0, gnt}, 32'd0);
        chk("abort_rst_done_vld", {31'd0, done_vld}, 32'd0);
        chk("abort_rst_done_count", {24'd0, done_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done_vld}, 32'd0);
        end
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1;
        run_burst(0, 32'b111, 3, 32'b110, 2, -1, 0);
        @(negedge clk); @(negedge clk);

        // Single-bit pattern: 6 matches, saturating at 3 in the 2-bit instance.
        cfg_pattern = 8'h01; cfg_len = 4'd1;
        run_burst(1, 32'b111111, 6, 32'b111111, 6, -1, 0);
        @(negedge clk); @(negedge clk);
        cfg_len = 4'd0;
        run_burst(2, 32'b101, 3, 32'b101, 2, -1, 0);
        @(negedge clk); @(negedge clk);
        cfg_pattern = 8'hA5; cfg_len = 4'd15;
        run_burst(3, 32'hA5, 8, 32'h80, 1, -1, 0);
        @(negedge clk); @(negedge clk);
        cfg_pattern = 8'h00; cfg_len = 4'd1;
        run_burst(0, 32'b1, 1, 32'b0, 0, -1, 0);
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        chk("queue2_empty", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
